// File: rtl/phy_rx_serial_paralelo.sv
// Serial-to-parallel receive stage: hunts for COMMA byte alignment, locks after
// LOCK_COMMAS aligned commas, then emits one byte per 8 clk_32f edges.
module phy_rx_serial_paralelo #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter logic [7:0]  IDLE        = 8'h7C,
  parameter int unsigned LOCK_COMMAS = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] LOCK_N = 5'(LOCK_COMMAS);

  state_t      state_q, state_d;
  // Only the seven newest bits are ever needed to build the next byte.
  logic [6:0]  sr_q, sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  bc_cnt_q, bc_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        strobe_q, strobe_d;
  logic        active_q, active_d;

  logic [7:0]  sr_next;
  logic        is_comma;
  logic        boundary;
  logic [4:0]  bc_plus1;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    sr_next   = {sr_q, data_in};
    is_comma  = (sr_next == COMMA);
    boundary  = (bit_cnt_q == 3'd7);
    bc_plus1  = {1'b0, bc_cnt_q} + 5'd1;

    state_d   = state_q;
    sr_d      = sr_next[6:0];
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    active_d  = active_q;

    unique case (state_q)
      SEARCH: begin
        // Bit-by-bit hunt; bit_cnt is restarted from the matching edge.
        if (is_comma) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          if (LOCK_N == 5'd1) begin
            state_d  = LOCKED;
            active_d = 1'b1;
          end else begin
            state_d  = ALIGN;
          end
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_plus1 == LOCK_N) begin
              state_d  = LOCKED;
              active_d = 1'b1;
            end
          end else begin
            state_d  = SEARCH;
            bc_cnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d   = sr_next;
          strobe_d = 1'b1;
          valid_d  = (sr_next != COMMA) && (sr_next != IDLE);
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// Directed bench for phy_rx_serial_paralelo: a LOCK_COMMAS=4 instance driven
// from a byte table plus hand sequences, and a LOCK_COMMAS=1 instance.
module tb_phy_rx_serial_paralelo;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       din_a, din_b;
  logic [7:0] dout_a, dout_b;
  logic       valid_a, valid_b, strobe_a, strobe_b, active_a, active_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_32f = ~clk_32f;

  phy_rx_serial_paralelo #(.LOCK_COMMAS(4)) dut_a (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (din_a),
    .data_out    (dout_a),
    .valid_out   (valid_a),
    .byte_strobe (strobe_a),
    .active      (active_a)
  );

  phy_rx_serial_paralelo #(.LOCK_COMMAS(1)) dut_b (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (din_b),
    .data_out    (dout_b),
    .valid_out   (valid_b),
    .byte_strobe (strobe_b),
    .active      (active_b)
  );

  typedef struct {
    bit         rst;
    logic [7:0] din;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_active;
    bit         exp_strobe;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Drives one byte MSB first; counts strobes seen on the first seven edges.
  task automatic send_byte(input logic [7:0] b, input bit sel, output int early);
    early = 0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk_32f);
      if (sel) din_b = b[i];
      else     din_a = b[i];
      @(posedge clk_32f);
      #1;
      if (i != 0 && (sel ? strobe_b : strobe_a)) early++;
    end
  endtask

  initial begin
    int early;

    vecs[0]  = '{1'b1, 8'hAB, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h7C, 8'h7C, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h7C, 8'h7C, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 8'h7C, 8'h7C, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h7C, 8'h7C, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'hBC, 8'hBC, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    din_a = 1'b0;
    din_b = 1'b0;
    @(posedge clk_32f);
    #1;
    check("rst_data", dout_a, 8'h00);
    check_b("rst_valid", valid_a, 1'b0);
    check_b("rst_strobe", strobe_a, 1'b0);
    check_b("rst_active", active_a, 1'b0);
    @(negedge clk_32f);
    reset = 1'b0;

    for (int v = 0; v < 20; v++) begin
      if (vecs[v].rst) pulse_reset();
      send_byte(vecs[v].din, 1'b0, early);
      $display("vec %0d din=%02h data_out=%02h valid=%0b active=%0b strobe=%0b",
               v, vecs[v].din, dout_a, valid_a, active_a, strobe_a);
      check($sformatf("v%0d_data", v), dout_a, vecs[v].exp_data);
      check_b($sformatf("v%0d_valid", v), valid_a, vecs[v].exp_valid);
      check_b($sformatf("v%0d_active", v), active_a, vecs[v].exp_active);
      check_b($sformatf("v%0d_strobe", v), strobe_a, vecs[v].exp_strobe);
      check($sformatf("v%0d_early_strobe", v), 8'(early), 8'd0);
    end

    // Asynchronous reset in the middle of a byte while locked.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_32f);
      din_a = 1'b1;
      @(posedge clk_32f);
      #1;
    end
    check_b("pre_async_active", active_a, 1'b1);
    reset = 1'b1;
    #1;
    $display("async reset: data_out=%02h valid=%0b active=%0b strobe=%0b",
             dout_a, valid_a, active_a, strobe_a);
    check("async_data", dout_a, 8'h00);
    check_b("async_valid", valid_a, 1'b0);
    check_b("async_strobe", strobe_a, 1'b0);
    check_b("async_active", active_a, 1'b0);
    @(negedge clk_32f);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_byte(8'hBC, 1'b0, early);
      $display("relock BC %0d: active=%0b strobe=%0b", k, active_a, strobe_a);
      check_b($sformatf("relock%0d_active", k), active_a, (k == 3));
      check_b($sformatf("relock%0d_strobe", k), strobe_a, 1'b0);
      check($sformatf("relock%0d_data", k), dout_a, 8'h00);
    end

    // LOCK_COMMAS=1 instance: one comma locks, next byte is delivered.
    pulse_reset();
    send_byte(8'hBC, 1'b1, early);
    $display("lock1 BC: active=%0b strobe=%0b data_out=%02h", active_b, strobe_b, dout_b);
    check_b("l1_active", active_b, 1'b1);
    check_b("l1_strobe", strobe_b, 1'b0);
    check("l1_data", dout_b, 8'h00);
    send_byte(8'hA5, 1'b1, early);
    $display("lock1 A5: data_out=%02h valid=%0b strobe=%0b", dout_b, valid_b, strobe_b);
    check("l1_a5_data", dout_b, 8'hA5);
    check_b("l1_a5_valid", valid_b, 1'b1);
    check_b("l1_a5_strobe", strobe_b, 1'b1);
    check("l1_a5_early", 8'(early), 8'd0);
    @(posedge clk_32f);
    #1;
    check_b("l1_strobe_drop", strobe_b, 1'b0);
    check("l1_data_hold", dout_b, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
